// File: rtl/apresenta_pkg.sv
// Shared definitions for the sequence presenter: FSM state encoding,
// default interval lengths and a small helper for sizing the timer.
package apresenta_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int TEMPO_ACESO_PADRAO   = 1000;
  localparam int TEMPO_APAGADO_PADRAO = 500;

  // Larger of two interval lengths; the shared timer must cover both phases.
  function automatic int maior(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apresenta_sequencia_contador_tempo.sv
// Modulo-M up-counter used as the phase timer of the presenter.
// The terminal value is an input so a single instance can time both the
// on and the off interval; the owner picks the limit for the active phase.
module contador_tempo #(
  parameter int M = 4,
  parameter int W = $clog2(M + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  input  logic [W-1:0] ultimo,
  output logic [W-1:0] valor,
  output logic         fim
);

  // Count register: clear has priority over enable, wraps at M-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= {W{1'b0}};
    end else if (limpa) begin
      valor <= {W{1'b0}};
    end else if (conta) begin
      if (valor == W'(M - 1)) begin
        valor <= {W{1'b0}};
      end else begin
        valor <= valor + W'(1);
      end
    end else begin
      valor <= valor;
    end
  end

  // Terminal count only reported while counting, so an idle timer never fires.
  assign fim = conta && (valor == ultimo);

endmodule

// File: rtl/apresenta_sequencia.sv
// Sequence presenter: plays RAM entries 0..rodada on the LEDs, each for an
// on interval followed by an off interval, then pulses pronto.
// Optional feature: define APRESENTA_ABORTA_EN to add the abortar input,
// which returns the block to OCIOSO from any active state without pronto.
module apresenta_sequencia
  import apresenta_pkg::*;
#(
  parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
  parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
`ifdef APRESENTA_ABORTA_EN
  input  logic       abortar,
`endif
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_dado,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam int M = maior(TEMPO_ACESO, TEMPO_APAGADO);
  localparam int W = $clog2(M + 1);

  estado_t      estado_r;
  estado_t      estado_prox;
  logic [3:0]   mem_addr_r;
  logic [3:0]   addr_prox;
  logic [3:0]   rodada_r;
  logic [3:0]   rodada_prox;
  logic [3:0]   leds_r;
  logic [3:0]   leds_prox;
  logic         ocupado_r;
  logic         pronto_r;
  logic         limpa;
  logic         conta;
  logic         aborta;
  logic [W-1:0] ultimo;
  logic [W-1:0] tempo_valor;
  logic         tempo_fim;

`ifdef APRESENTA_ABORTA_EN
  assign aborta = abortar && (estado_r != OCIOSO);
`else
  assign aborta = 1'b0;
`endif

  // The on interval uses its own limit; every other phase uses the off limit.
  assign ultimo = (estado_r == ACESO) ? W'(TEMPO_ACESO - 1) : W'(TEMPO_APAGADO - 1);

  contador_tempo #(
    .M (M),
    .W (W)
  ) u_tempo (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa),
    .conta  (conta),
    .ultimo (ultimo),
    .valor  (tempo_valor),
    .fim    (tempo_fim)
  );

  // Next-state, next-address, next-LED and timer control decode.
  always_comb begin
    estado_prox = estado_r;
    addr_prox   = mem_addr_r;
    rodada_prox = rodada_r;
    leds_prox   = leds_r;
    limpa       = 1'b0;
    conta       = 1'b0;
    if (aborta) begin
      estado_prox = OCIOSO;
      leds_prox   = 4'd0;
      limpa       = 1'b1;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (iniciar) begin
            rodada_prox = rodada;
            addr_prox   = 4'd0;
            limpa       = 1'b1;
            estado_prox = BUSCA;
          end else begin
            estado_prox = OCIOSO;
          end
        end
        BUSCA: begin
          // RAM data for mem_addr is valid by the end of this slot.
          leds_prox   = mem_dado;
          limpa       = 1'b1;
          estado_prox = ACESO;
        end
        ACESO: begin
          conta = 1'b1;
          if (tempo_fim) begin
            leds_prox   = 4'd0;
            limpa       = 1'b1;
            estado_prox = APAGADO;
          end else begin
            estado_prox = ACESO;
          end
        end
        APAGADO: begin
          conta = 1'b1;
          if (tempo_fim) begin
            limpa       = 1'b1;
            estado_prox = PROXIMO;
          end else begin
            estado_prox = APAGADO;
          end
        end
        PROXIMO: begin
          // Stop on the last requested entry so the address never wraps.
          if (mem_addr_r == rodada_r) begin
            estado_prox = FIM;
          end else begin
            addr_prox   = mem_addr_r + 4'd1;
            estado_prox = BUSCA;
          end
        end
        FIM: begin
          estado_prox = OCIOSO;
        end
        default: begin
          leds_prox   = 4'd0;
          limpa       = 1'b1;
          estado_prox = OCIOSO;
        end
      endcase
    end
  end

  // State, address, captured round, LED and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r   <= OCIOSO;
      mem_addr_r <= 4'd0;
      rodada_r   <= 4'd0;
      leds_r     <= 4'd0;
      ocupado_r  <= 1'b0;
      pronto_r   <= 1'b0;
    end else begin
      estado_r   <= estado_prox;
      mem_addr_r <= addr_prox;
      rodada_r   <= rodada_prox;
      leds_r     <= leds_prox;
      ocupado_r  <= (estado_prox != OCIOSO);
      pronto_r   <= (estado_prox == FIM);
    end
  end

  assign mem_addr  = mem_addr_r;
  assign leds      = leds_r;
  assign ocupado   = ocupado_r;
  assign pronto    = pronto_r;
  assign db_estado = estado_r;

endmodule
